sv_rnd_rsp: RTL and testbench

// Responder side of the one-cycle request / response random-number handshake.
// - A requester pulses u_i for one cycle. This block generates a DATA_WIDTH-bit pseudo-random word.
// - It then pulses r_o for one cycle with the word on rnd_o.
// - The generator is a seedable xorshift64. It runs ROUND_PER_TACT rounds per clock.
// - It sits between the signature core's nonce requesters and the entropy/seed source.

---
 rtl/sv_rnd_rsp.sv | 143 ++++++++++++++
 tb/tb_sv_rnd_rsp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_rnd_rsp.sv
// Random-number responder: a one-cycle request on u_i starts an xorshift64
// generator that fills rnd_o chunk by chunk, then r_o pulses for one cycle
// with the finished word. One extra request can be queued while generating;
// any further request is dropped and flagged on the sticky ovf_o.
module sv_rnd_rsp #(
  parameter int          DATA_WIDTH     = 512,
  parameter int          ROUND_PER_TACT = 4,
  parameter logic [63:0] SEED           = 64'h1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  u_i,
  output logic                  r_o,
  output logic [DATA_WIDTH-1:0] rnd_o,
  input  logic                  seed_v_i,
  input  logic [63:0]           seed_i,
  output logic                  busy_o,
  output logic                  ovf_o
);

  // One clock produces CHUNK_W bits; NCYC clocks fill the whole word.
  localparam int CHUNK_W = 64 * ROUND_PER_TACT;
  localparam int NCYC    = DATA_WIDTH / CHUNK_W;
  localparam int CNT_W   = $clog2(NCYC) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 r_q, r_d;
  logic                 seed_ld;
  logic                 gen_en;
  logic [63:0]          x_q;
  logic [63:0]          x_nxt;
  logic [CHUNK_W-1:0]   blk;
  logic [DATA_WIDTH-1:0] rnd_q;

  // One xorshift64 round.
  function automatic logic [63:0] xs_round(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Chain ROUND_PER_TACT rounds from the current state; round i lands in chunk i of the block.
  always_comb begin
    logic [63:0] t;
    t   = x_q;
    blk = '0;
    for (int i = 0; i < ROUND_PER_TACT; i++) begin
      t = xs_round(t);
      blk[64*i +: 64] = t;
    end
    x_nxt = t;
  end

  // Next-state and control decode for the IDLE / GEN / DONE handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    r_d     = 1'b0;
    seed_ld = 1'b0;
    gen_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // Seed loads on the same edge the request is accepted, so generation uses it.
        seed_ld = seed_v_i;
        if (u_i) begin
          state_d = GEN;
          cnt_d   = '0;
        end
      end
      GEN: begin
        gen_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          r_d     = 1'b1;
        end
        // Only one request can wait; a second one while waiting is lost.
        if (u_i) begin
          if (pend_q) ovf_d = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      DONE: begin
        if (pend_q || u_i) begin
          state_d = GEN;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      r_q     <= r_d;
    end
  end

  // Generator state and output word; the word is filled block by block, LSB first.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      x_q   <= SEED;
      rnd_q <= '0;
    end else if (seed_ld) begin
      x_q <= (seed_i == 64'd0) ? SEED : seed_i;
    end else if (gen_en) begin
      x_q <= x_nxt;
      for (int k = 0; k < NCYC; k++) begin
        if (cnt_q == CNT_W'(k)) rnd_q[k*CHUNK_W +: CHUNK_W] <= blk;
      end
    end
  end

  assign r_o    = r_q;
  assign rnd_o  = rnd_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_sv_rnd_rsp.sv
// Bench for sv_rnd_rsp: default-parameter instance plus a narrow
// (ROUND_PER_TACT=1, DATA_WIDTH=256) instance, against a plain xorshift64 model.
module tb_sv_rnd_rsp;

  logic         clk = 1'b0;
  logic         areset;
  logic         u_i, seed_v_i;
  logic [63:0]  seed_i;
  logic         r_o, busy_o, ovf_o;
  logic [511:0] rnd_o;

  logic         u1, sv1;
  logic [63:0]  s1;
  logic         r1, busy1, ovf1;
  logic [255:0] rnd1;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]  mx;
  logic [63:0]  mx1;
  logic [511:0] word1;
  int           pt[$];
  logic [511:0] pw[$];

  sv_rnd_rsp dut (
    .clk(clk), .areset(areset), .u_i(u_i), .r_o(r_o), .rnd_o(rnd_o),
    .seed_v_i(seed_v_i), .seed_i(seed_i), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  sv_rnd_rsp #(.DATA_WIDTH(256), .ROUND_PER_TACT(1), .SEED(64'h1)) dut1 (
    .clk(clk), .areset(areset), .u_i(u1), .r_o(r1), .rnd_o(rnd1),
    .seed_v_i(sv1), .seed_i(s1), .busy_o(busy1), .ovf_o(ovf1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end

  // Reference: C xorshift64 step.
  function automatic logic [63:0] xs(input logic [63:0] v);
    v ^= v << 13;
    v ^= v >> 7;
    v ^= v << 17;
    return v;
  endfunction

  // Next nch numbers of the sequence, packed LSB chunk first.
  task automatic model_word(inout logic [63:0] x, input int nch, output logic [511:0] w);
    w = '0;
    for (int k = 0; k < nch; k++) begin
      x = xs(x);
      w[64*k +: 64] = x;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive u_i per mask bit per cycle (cycle 0 = first bit); log r_o pulses by cycle.
  task automatic run(input logic [15:0] umask, input int ncyc);
    pt.delete();
    pw.delete();
    for (int c = 0; c < ncyc; c++) begin
      u_i = (c < 16) ? umask[c] : 1'b0;
      step();
      u_i = 1'b0;
      seed_v_i = 1'b0;
      if (r_o === 1'b1) begin
        pt.push_back(c + 1);
        pw.push_back(rnd_o);
      end
    end
  endtask

  task automatic load_seed(input logic [63:0] s);
    seed_v_i = 1'b1;
    seed_i = s;
    step();
    seed_v_i = 1'b0;
    mx = (s == 64'd0) ? 64'h1 : s;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    u_i = 0; seed_v_i = 0; seed_i = 0; u1 = 0; sv1 = 0; s1 = 0;
    #2 areset = 1'b0;
    #1;
    n_cmp++; if (r_o !== 1'b0) begin n_err++; $display("FAIL reset_r: got %b want 0", r_o); end
    n_cmp++; if (rnd_o !== 512'd0) begin n_err++; $display("FAIL reset_rnd: got %0h want 0", rnd_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    step(); step();
    areset = 1'b1;
    step();
    mx = 64'h1;
    mx1 = 64'h1;
  endtask

  task automatic test_seed_one();
    logic [511:0] e;
    load_seed(64'h1);
    run(16'h1, 8);
    model_word(mx, 8, e);
    word1 = e;
    n_cmp++;
    if (pt.size() !== 1) begin
      n_err++; $display("FAIL s1_pulses: got %0d want 1", pt.size());
    end else begin
      n_cmp++; if (pt[0] !== 3) begin n_err++; $display("FAIL s1_latency: got %0d want 3", pt[0]); end
      n_cmp++; if (pw[0][63:0] !== 64'h0000_0000_4082_2041) begin n_err++; $display("FAIL s1_chunk0: got %0h want 40822041", pw[0][63:0]); end
      n_cmp++; if (pw[0] !== e) begin n_err++; $display("FAIL s1_word: got %0h want %0h", pw[0], e); end
    end
    n_cmp++; if (rnd_o !== e) begin n_err++; $display("FAIL s1_hold: got %0h want %0h", rnd_o, e); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL s1_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_zero_seed();
    logic [511:0] e;
    seed_v_i = 1'b1;
    seed_i = 64'd0;
    mx = 64'h1;
    run(16'h1, 6);
    model_word(mx, 8, e);
    n_cmp++;
    if (pt.size() !== 1) begin
      n_err++; $display("FAIL s2_pulses: got %0d want 1", pt.size());
    end else begin
      n_cmp++; if (pw[0] !== word1) begin n_err++; $display("FAIL s2_same_as_s1: got %0h want %0h", pw[0], word1); end
      n_cmp++; if (pw[0] !== e) begin n_err++; $display("FAIL s2_word: got %0h want %0h", pw[0], e); end
    end
  endtask

  // Two requests a cycle apart: both served, sequence continues, no overflow.
  task automatic test_back_to_back();
    logic [511:0] e0, e1;
    load_seed({$urandom, $urandom});
    run(16'b11, 10);
    model_word(mx, 8, e0);
    model_word(mx, 8, e1);
    n_cmp++;
    if (pt.size() !== 2) begin
      n_err++; $display("FAIL s3_pulses: got %0d want 2", pt.size());
    end else begin
      n_cmp++; if (pt[0] !== 3) begin n_err++; $display("FAIL s3_lat: got %0d want 3", pt[0]); end
      n_cmp++; if (pt[1] - pt[0] !== 3) begin n_err++; $display("FAIL s3_gap: got %0d want 3", pt[1] - pt[0]); end
      n_cmp++; if (pw[0] !== e0) begin n_err++; $display("FAIL s3_word0: got %0h want %0h", pw[0], e0); end
      n_cmp++; if (pw[1] !== e1) begin n_err++; $display("FAIL s3_word1: got %0h want %0h", pw[1], e1); end
    end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL s3_ovf: got %b want 0", ovf_o); end
  endtask

  // Request arriving in the DONE cycle is served right away.
  task automatic test_done_rereq();
    logic [511:0] e0, e1;
    load_seed({$urandom, $urandom});
    run(16'b1001, 10);
    model_word(mx, 8, e0);
    model_word(mx, 8, e1);
    n_cmp++;
    if (pt.size() !== 2) begin
      n_err++; $display("FAIL done_pulses: got %0d want 2", pt.size());
    end else begin
      n_cmp++; if (pt[1] !== 6) begin n_err++; $display("FAIL done_lat: got %0d want 6", pt[1]); end
      n_cmp++; if (pw[1] !== e1) begin n_err++; $display("FAIL done_word1: got %0h want %0h", pw[1], e1); end
    end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL done_ovf: got %b want 0", ovf_o); end
  endtask

  // Three consecutive requests: third is dropped, ovf_o sticks.
  task automatic test_overflow();
    logic [511:0] e0, e1;
    load_seed({$urandom, $urandom});
    run(16'b111, 12);
    model_word(mx, 8, e0);
    model_word(mx, 8, e1);
    n_cmp++;
    if (pt.size() !== 2) begin
      n_err++; $display("FAIL s4_pulses: got %0d want 2", pt.size());
    end else begin
      n_cmp++; if (pt[1] !== 6) begin n_err++; $display("FAIL s4_second: got %0d want 6", pt[1]); end
      n_cmp++; if (pw[1] !== e1) begin n_err++; $display("FAIL s4_word1: got %0h want %0h", pw[1], e1); end
    end
    n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL s4_ovf: got %b want 1", ovf_o); end
    load_seed({$urandom, $urandom});
    run(16'h1, 8);
    model_word(mx, 8, e0);
    n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL s4_ovf_sticky: got %b want 1", ovf_o); end
  endtask

  // Async reset in the middle of generation: nothing delivered, reset values back.
  task automatic test_reset_mid_gen();
    run(16'h1, 2);
    #1 areset = 1'b0;
    #1;
    n_cmp++; if (r_o !== 1'b0) begin n_err++; $display("FAIL s5_r: got %b want 0", r_o); end
    n_cmp++; if (rnd_o !== 512'd0) begin n_err++; $display("FAIL s5_rnd: got %0h want 0", rnd_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL s5_ovf: got %b want 0", ovf_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL s5_busy: got %b want 0", busy_o); end
    step();
    areset = 1'b1;
    mx = 64'h1;
    mx1 = 64'h1;
    run(16'h0, 6);
    n_cmp++; if (pt.size() !== 0) begin n_err++; $display("FAIL s5_no_rsp: got %0d pulses want 0", pt.size()); end
    run(16'h1, 6);
    n_cmp++;
    if (pt.size() !== 1) begin
      n_err++; $display("FAIL s5_pulses: got %0d want 1", pt.size());
    end else begin
      n_cmp++; if (pw[0] !== word1) begin n_err++; $display("FAIL s5_word: got %0h want %0h", pw[0], word1); end
    end
    model_word(mx, 8, word1);
  endtask

  // Random seeds (including zero) with random idle gaps between single requests.
  task automatic test_random();
    logic [511:0] e;
    logic [63:0]  s;
    for (int it = 0; it < 8; it++) begin
      s = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      load_seed(s);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      run(16'h1, 5);
      model_word(mx, 8, e);
      n_cmp++;
      if (pt.size() !== 1 || pw[0] !== e) begin
        n_err++; $display("FAIL rand_word[%0d]: got %0d pulses last %0h want %0h", it, pt.size(), rnd_o, e);
      end
    end
  endtask

  // Narrow instance: 4 cycles per word, busy window, seed ignored during GEN.
  task automatic test_narrow();
    logic [511:0] e;
    logic [63:0]  s;
    int           waited;
    s = {$urandom, $urandom};
    sv1 = 1'b1; s1 = s;
    step();
    sv1 = 1'b0;
    mx1 = (s == 64'd0) ? 64'h1 : s;
    model_word(mx1, 4, e);
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL s6_busy_pre: got %b want 0", busy1); end
    u1 = 1'b1;
    step();
    u1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_cmp++; if (busy1 !== (c <= 5)) begin n_err++; $display("FAIL s6_busy[%0d]: got %b want %b", c, busy1, c <= 5); end
      n_cmp++; if (r1 !== (c == 5)) begin n_err++; $display("FAIL s6_r[%0d]: got %b want %b", c, r1, c == 5); end
      if (c == 5) begin
        n_cmp++; if (rnd1 !== e[255:0]) begin n_err++; $display("FAIL s6_word: got %0h want %0h", rnd1, e[255:0]); end
      end
      sv1 = (c == 2);
      s1 = {$urandom, $urandom};
      step();
      sv1 = 1'b0;
    end
    model_word(mx1, 4, e);
    u1 = 1'b1;
    step();
    u1 = 1'b0;
    waited = 1;
    while (r1 !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_cmp++; if (waited !== 5) begin n_err++; $display("FAIL s6_lat2: got %0d want 5", waited); end
    n_cmp++; if (rnd1 !== e[255:0]) begin n_err++; $display("FAIL s6_continue: got %0h want %0h", rnd1, e[255:0]); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL s6_ovf: got %b want 0", ovf1); end
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_zero_seed();
    test_back_to_back();
    test_done_rereq();
    test_overflow();
    test_reset_mid_gen();
    test_random();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
